qpsk_carrier_modulator: RTL and testbench
=========================================

// Module: qpsk_carrier_modulator
// PURPOSE
//  Maps a 2-bit QPSK symbol onto a phase-shifted sampled sinusoidal carrier.
//  Signed fixed-point output, one sample per clock.
//  Sits between the symbol source (bit-pair framer) and the DAC / fixed-point datapath.
//  Carrier comes from an internal ROM: one full sine period, quarter-wave symmetric.
//  Phase index advances by 1 every clock.
// PARAMETERS
//  OUT_W   `FIXDT_64_A_WIDTH (16 if macro undefined)  output sample width, signed two's complement
//  N_SAMP  64                                         samples per carrier period; power of 2, >= 8
// PORTS
//  clk  in   1      system clock, all logic on rising edge
//  rst  in   1      asynchronous, active-high reset
//  in   in   2      QPSK symbol (dibit)
//  out  out  OUT_W  modulated carrier sample, registered
// BEHAVIOUR
//  - Reset (async assert, sync release): idx=0, sym_reg=2'b00, out=0.
//  - idx: log2(N_SAMP)-bit counter, +1 per clk, wraps N_SAMP-1 -> 0.
//  - ROM: S(k) = round(sin(2*pi*k/N_SAMP) * (2^(OUT_W-1)-1)).
//    Never reaches -2^(OUT_W-1), so the output is symmetric.
//  - Gray phase map, with Q = N_SAMP/8:
//    00 -> 45 deg (off=Q), 01 -> 135 deg (3Q), 11 -> 225 deg (5Q), 10 -> 315 deg (7Q).
//  - Each clk: out <= S((idx + off(sym_eff)) mod N_SAMP). Offset add wraps modulo N_SAMP.
//  - Latency: 1 clk from sym_eff and idx to out.
//  - k-th rising edge after reset release (k>=1): out = S((k-1+off) mod N_SAMP).
//  - No handshake. The symbol is sampled every clock.
//    Changing `in` mid-period produces an immediate phase jump (see CONFIGURATION).
//  - Reset mid-operation: out, idx and sym_reg clear immediately (async).
//    Carrier restarts from idx=0 on release.
//  - `in` X/Z is not tolerated. Upstream must drive a valid dibit whenever rst=0.
// CONFIGURATION
//  QPSK_PERIOD_ALIGN_EN defined:
//    - sym_eff = sym_reg.
//    - sym_reg <= in only on the edge where idx == N_SAMP-1.
//    - Phase changes occur only at carrier-period boundaries.
//    - After reset, symbol 00 is used until the first wrap.
//  QPSK_PERIOD_ALIGN_EN undefined:
//    - sym_eff = in (combinational into the output register).
//    - sym_reg is unused and may be removed.
//    - Symbol change is visible at out on the next edge.
// TESTING  (OUT_W=16, N_SAMP=64; A=32767; S(8)=S(24)=23170; S(40)=S(56)=-23170; S(16)=32767)
//  1. rst=1, in=00 -> out=0 throughout reset, including a clk running under reset.
//  2. Release rst, in=00 -> edges 1..4 give S(8), S(9), S(10), S(11).
//     out repeats with period 64 clks.
//  3. Hold each of 00/01/11/10 from reset -> first sample 23170 / 23170 / -23170 / -23170.
//     Sample 9 (k=9) = 32767 / 0 / -32767 / 0.
//  4. Align off: switch in 00->01 at idx=3 -> next out = S(3+24) = S(27), no delay.
//  5. Align on: switch in 00->11 at idx=3 -> out keeps the 00 phase until after idx 63.
//     The edge after the wrap gives S(0+40) = -23170.
//  6. Assert rst mid-period -> out=0 within the same time step (no clk needed).
//     Release -> sequence restarts exactly as in scenario 2.

Source files
------------

// File: rtl/qpsk_carrier_modulator.sv
// QPSK modulator: Gray-coded dibit selects a 45/135/225/315 deg phase offset into a quarter-wave sine ROM.
// OUT_W defaults to 16; QPSK_PERIOD_ALIGN_EN latches the symbol only at carrier wrap.
module qpsk_carrier_modulator #(
   parameter int OUT_W  = 16,
   parameter int N_SAMP = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [1:0]              in,
   output logic signed [OUT_W-1:0] out
);

   localparam int IDX_W = $clog2(N_SAMP);
   localparam int QW    = N_SAMP / 4;
   localparam logic [IDX_W-1:0] ONE = IDX_W'(1);
   localparam logic [IDX_W-2:0] QTR = (IDX_W-1)'(QW);

   // Elaboration-time ROM entry: rounded sine for the first quarter (all values >= 0).
   function automatic logic signed [OUT_W-1:0] rom_val(input int k);
      real amp;
      real x;
      amp = (2.0 ** (OUT_W - 1)) - 1.0;
      x   = $sin(2.0 * 3.14159265358979323846 * real'(k) / real'(N_SAMP)) * amp;
      return OUT_W'($rtoi(x + 0.5));
   endfunction

   function automatic logic [IDX_W-1:0] sym_off(input logic [1:0] sym);
      case (sym)
         2'b00:   sym_off = IDX_W'(1 * N_SAMP / 8);
         2'b01:   sym_off = IDX_W'(3 * N_SAMP / 8);
         2'b11:   sym_off = IDX_W'(5 * N_SAMP / 8);
         default: sym_off = IDX_W'(7 * N_SAMP / 8);
      endcase
   endfunction

   logic signed [OUT_W-1:0] qrom [0:QW];

   for (genvar i = 0; i <= QW; i++) begin : g_rom
      localparam logic signed [OUT_W-1:0] VAL = rom_val(i);
      assign qrom[i] = VAL;
   end

   logic [IDX_W-1:0]        idx;
   logic [1:0]              sym_eff;
   logic [IDX_W-1:0]        addr;
   logic [IDX_W-2:0]        sub_lo;
   logic [IDX_W-2:0]        sub_hi;
   logic signed [OUT_W-1:0] sample;

`ifdef QPSK_PERIOD_ALIGN_EN
   logic [1:0] sym_reg;

   // Symbol is only allowed to change on the edge that wraps the carrier.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         sym_reg <= 2'b00;
      else if (idx == IDX_W'(N_SAMP - 1))
         sym_reg <= in;
   end

   assign sym_eff = sym_reg;
`else
   assign sym_eff = in;
`endif

   // NOTE: every variable gets a default before the case so no latch can be inferred.
   always_comb begin
      addr   = idx + sym_off(sym_eff);
      sub_lo = {1'b0, addr[IDX_W-3:0]};
      sub_hi = QTR - sub_lo;
      sample = '0;
      case (addr[IDX_W-1:IDX_W-2])
         2'b00:   sample = qrom[sub_lo];
         2'b01:   sample = qrom[sub_hi];
         2'b10:   sample = -qrom[sub_lo];
         default: sample = -qrom[sub_hi];
      endcase
   end

   // NOTE: non-blocking assignments keep all registers updating from pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx <= '0;
         out <= '0;
      end else begin
         idx <= idx + ONE;
         out <= sample;
      end
   end

endmodule

// File: tb/tb_qpsk_carrier_modulator.sv
// Directed bench for qpsk_carrier_modulator (OUT_W=16, N_SAMP=64); adapts to QPSK_PERIOD_ALIGN_EN.
module tb_qpsk_carrier_modulator;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic [1:0]         in  = 2'b00;
   logic signed [15:0] out;

   int total = 0;
   int bad   = 0;

`ifdef QPSK_PERIOD_ALIGN_EN
   localparam bit ALIGN = 1'b1;
`else
   localparam bit ALIGN = 1'b0;
`endif

   // Reference state: carrier index and latched symbol after each edge.
   int         m_idx = 0;
   logic [1:0] m_sym = 2'b00;

   qpsk_carrier_modulator dut (
      .clk (clk),
      .rst (rst),
      .in  (in),
      .out (out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Full-period reference sine, independent of the quarter-wave ROM folding.
   function automatic int s_ref(input int k);
      real v;
      v = $sin(2.0 * 3.14159265358979323846 * real'(k % 64) / 64.0) * 32767.0;
      return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
   endfunction

   function automatic int off_ref(input logic [1:0] s);
      case (s)
         2'b00:   return 8;
         2'b01:   return 24;
         2'b11:   return 40;
         default: return 56;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One clock with the expected sample predicted from the reference state.
   task automatic step(input string tag);
      logic [1:0] eff;
      int         exp;
      eff = ALIGN ? m_sym : in;
      exp = s_ref(m_idx + off_ref(eff));
      if (ALIGN && m_idx == 63) m_sym = in;
      m_idx = (m_idx + 1) % 64;
      tick();
      check(tag, int'(out), exp);
   endtask

   // Async assert away from the edge, one clock under reset, release just after an edge.
   task automatic do_reset(input logic [1:0] sym);
      rst = 1'b1;
      in  = sym;
      #1;
      check("rst_async", int'(out), 0);
      tick();
      check("rst_clk", int'(out), 0);
      rst   = 1'b0;
      m_idx = 0;
      m_sym = 2'b00;
   endtask

   initial begin
      logic [1:0] syms [4];
      int         first_exp [4];
      int         ninth_exp [4];
      syms      = '{2'b00, 2'b01, 2'b11, 2'b10};
      first_exp = '{23170, 23170, -23170, -23170};
      ninth_exp = '{32767, 0, -32767, 0};

      // Reset held with the clock running.
      #1;
      check("rst_init", int'(out), 0);
      repeat (3) begin
         tick();
         check("rst_hold", int'(out), 0);
      end
      rst = 1'b0;

      // Carrier from reset with symbol 00.
      step("seq_k1");
      check("seq_k1_const", int'(out), 23170);
      step("seq_k2");
      step("seq_k3");
      step("seq_k4");
      for (int k = 5; k <= 65; k++) step("seq_period");
      check("seq_k65_repeat", int'(out), 23170);
      step("seq_k66");

      // Each symbol held from reset.
      for (int s = 0; s < 4; s++) begin
         do_reset(syms[s]);
         step("sym_first");
         check("sym_first_const", int'(out), ALIGN ? 23170 : first_exp[s]);
         for (int k = 2; k <= 9; k++) step("sym_run");
         check("sym_ninth_const", int'(out), ALIGN ? 32767 : ninth_exp[s]);
      end

      // Symbol switch at idx 3.
      do_reset(2'b00);
      repeat (3) step("sw_pre");
      if (ALIGN) begin
         in = 2'b11;
         for (int k = 4; k <= 64; k++) step("sw_hold");
         check("sw_hold_k64", int'(out), s_ref(63 + 8));
         step("sw_wrap");
         check("sw_wrap_const", int'(out), -23170);
         step("sw_after");
      end else begin
         in = 2'b01;
         step("sw_jump");
         check("sw_jump_s27", int'(out), s_ref(27));
         step("sw_after");
         in = 2'b10;
         step("sw_jump2");
         check("sw_jump2_s61", int'(out), s_ref(5 + 56));
      end

      // Reset mid-period, then restart as from the first reset.
      in = 2'b00;
      repeat (7) step("mid_pre");
      do_reset(2'b00);
      step("mid_k1");
      check("mid_k1_const", int'(out), 23170);
      step("mid_k2");
      check("mid_k2_s9", int'(out), s_ref(9));
      step("mid_k3");
      step("mid_k4");
      check("mid_k4_s11", int'(out), s_ref(11));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
